soc_system_sysid_checker: RTL and testbench

// - Avalon-MM read master that sequences the system-ID slave after each start request.
// - Reads word 0 (ID), then word 1 (build timestamp), and compares both against expected values.
// - Reports pass/fail/timeout status to the HPS-visible status logic, gating bring-up of the ultrasound datapath.

---
 rtl/soc_system_sysid_checker.sv | 161 ++++++++++++++++
 tb/tb_soc_system_sysid_checker.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_system_sysid_checker.sv
// System-ID checker: reads ID and build timestamp from the sysid slave
// over Avalon-MM and reports match/timeout status for bring-up gating.
module soc_system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'd2899645186,
    parameter logic [31:0] EXPECTED_TS    = 32'd1640332522,
    parameter int          TIMEOUT_CYCLES = 256
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        m_address,
    output logic        m_read,
    input  logic        m_waitrequest,
    input  logic        m_readdatavalid,
    input  logic [31:0] m_readdata,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        busy,
    output logic        done,
    output logic        id_match,
    output logic        ts_match,
    output logic        timeout_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    typedef enum logic [2:0] {
        IDLE,
        RD_ID_REQ,
        RD_ID_WAIT,
        RD_TS_REQ,
        RD_TS_WAIT
    } state_t;

    state_t      state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic        m_address_d;
    logic        m_read_d;
    logic [31:0] id_value_d;
    logic [31:0] ts_value_d;
    logic        busy_d;
    logic        done_d;
    logic        id_match_d;
    logic        ts_match_d;
    logic        timeout_err_d;
    logic        expire;
    logic        abort;
    logic [CW-1:0] cnt_inc;

    assign expire  = (cnt == CNT_LAST);
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        m_address_d   = m_address;
        m_read_d      = m_read;
        id_value_d    = id_value;
        ts_value_d    = ts_value;
        busy_d        = busy;
        done_d        = 1'b0;
        id_match_d    = id_match;
        ts_match_d    = ts_match;
        timeout_err_d = timeout_err;
        abort         = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_d       = RD_ID_REQ;
                    cnt_d         = '0;
                    m_read_d      = 1'b1;
                    m_address_d   = 1'b0;
                    busy_d        = 1'b1;
                    id_match_d    = 1'b0;
                    ts_match_d    = 1'b0;
                    timeout_err_d = 1'b0;
                end
            end
            RD_ID_REQ, RD_TS_REQ: begin
                cnt_d = cnt_inc;
                // Only read data completes a read; an accept at expiry still aborts
                if (expire) begin
                    abort = 1'b1;
                end else if (!m_waitrequest) begin
                    m_read_d = 1'b0;
                    state_d  = (state == RD_ID_REQ) ? RD_ID_WAIT : RD_TS_WAIT;
                end
            end
            RD_ID_WAIT: begin
                cnt_d = cnt_inc;
                if (m_readdatavalid) begin
                    id_value_d  = m_readdata;
                    id_match_d  = (m_readdata == EXPECTED_ID);
                    state_d     = RD_TS_REQ;
                    cnt_d       = '0;
                    m_read_d    = 1'b1;
                    m_address_d = 1'b1;
                end else if (expire) begin
                    abort = 1'b1;
                end
            end
            RD_TS_WAIT: begin
                cnt_d = cnt_inc;
                if (m_readdatavalid) begin
                    ts_value_d  = m_readdata;
                    ts_match_d  = (m_readdata == EXPECTED_TS);
                    state_d     = IDLE;
                    m_address_d = 1'b0;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                end else if (expire) begin
                    abort = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort) begin
            state_d       = IDLE;
            m_read_d      = 1'b0;
            m_address_d   = 1'b0;
            busy_d        = 1'b0;
            done_d        = 1'b1;
            timeout_err_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            m_address   <= 1'b0;
            m_read      <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            id_match    <= 1'b0;
            ts_match    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            m_address   <= m_address_d;
            m_read      <= m_read_d;
            id_value    <= id_value_d;
            ts_value    <= ts_value_d;
            busy        <= busy_d;
            done        <= done_d;
            id_match    <= id_match_d;
            ts_match    <= ts_match_d;
            timeout_err <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_soc_system_sysid_checker.sv
// Directed bench for the sysid checker with a small Avalon slave model.
module tb_soc_system_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'hACD5_D902;
    localparam logic [31:0] EXP_TS = 32'h61C5_BCEA;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        m_address;
    logic        m_read;
    logic        m_waitrequest = 1'b0;
    logic        m_readdatavalid = 1'b0;
    logic [31:0] m_readdata = 32'h0;
    logic [31:0] id_value;
    logic [31:0] ts_value;
    logic        busy;
    logic        done;
    logic        id_match;
    logic        ts_match;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    // Slave configuration, written by the stimulus block only
    logic [31:0] id_word;
    logic [31:0] ts_word;
    logic        ts_drop;
    int          id_wait_cfg;

    // Slave internal state, written by the slave process only
    logic        pend_valid = 1'b0;
    logic [31:0] pend_data = 32'h0;
    int          id_stalls = 0;

    logic rd_hist   [0:63];
    logic addr_hist [0:63];

    soc_system_sysid_checker #(
        .EXPECTED_ID    (EXP_ID),
        .EXPECTED_TS    (EXP_TS),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .m_address       (m_address),
        .m_read          (m_read),
        .m_waitrequest   (m_waitrequest),
        .m_readdatavalid (m_readdatavalid),
        .m_readdata      (m_readdata),
        .id_value        (id_value),
        .ts_value        (ts_value),
        .busy            (busy),
        .done            (done),
        .id_match        (id_match),
        .ts_match        (ts_match),
        .timeout_err     (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Slave: decisions at negedge; data appears the cycle after accept
    always @(negedge clock) begin
        m_readdatavalid = pend_valid;
        m_readdata      = pend_valid ? pend_data : 32'h0;
        pend_valid      = 1'b0;
        if (m_read) begin
            if (!m_address && id_stalls < id_wait_cfg) begin
                m_waitrequest = 1'b1;
                id_stalls     = id_stalls + 1;
            end else begin
                m_waitrequest = 1'b0;
                pend_valid    = !(m_address && ts_drop);
                pend_data     = m_address ? ts_word : id_word;
            end
        end else begin
            m_waitrequest = 1'b0;
            id_stalls     = 0;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pulses start and returns the cycle in which done is seen (40 = never)
    task automatic run_check(output int cyc);
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        rd_hist[1]   = m_read;
        addr_hist[1] = m_address;
        while (!done && cyc < 40) begin
            tick();
            cyc++;
            rd_hist[cyc]   = m_read;
            addr_hist[cyc] = m_address;
        end
    endtask

    initial begin
        int cyc;
        int ndone;
        int d1;
        int d2;

        reset_n     = 1'b0;
        start       = 1'b0;
        id_word     = EXP_ID;
        ts_word     = EXP_TS;
        ts_drop     = 1'b0;
        id_wait_cfg = 0;

        tick();
        tick();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_m_read", m_read, 1'b0);
        check("rst_m_address", m_address, 1'b0);
        check("rst_id_value", id_value, 32'h0);
        check("rst_ts_value", ts_value, 32'h0);
        check("rst_id_match", id_match, 1'b0);
        check("rst_ts_match", ts_match, 1'b0);
        check("rst_timeout", timeout_err, 1'b0);
        reset_n = 1'b1;
        tick();
        tick();

        // Nominal
        run_check(cyc);
        check("nom_read_c1", rd_hist[1], 1'b1);
        check("nom_addr_c1", addr_hist[1], 1'b0);
        check("nom_ts_read_c3", rd_hist[3], 1'b1);
        check("nom_ts_addr_c3", addr_hist[3], 1'b1);
        check("nom_done_cycle", cyc, 5);
        check("nom_id_value", id_value, EXP_ID);
        check("nom_ts_value", ts_value, EXP_TS);
        check("nom_id_match", id_match, 1'b1);
        check("nom_ts_match", ts_match, 1'b1);
        check("nom_timeout", timeout_err, 1'b0);
        check("nom_busy", busy, 1'b0);
        tick();
        check("nom_done_pulse", done, 1'b0);
        check("nom_id_match_hold", id_match, 1'b1);
        tick();

        // Stall on ID read
        id_wait_cfg = 3;
        run_check(cyc);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("stall_read_c%0d", i), rd_hist[i], 1'b1);
            check($sformatf("stall_addr_c%0d", i), addr_hist[i], 1'b0);
        end
        check("stall_read_c5", rd_hist[5], 1'b0);
        check("stall_done_cycle", cyc, 8);
        check("stall_id_match", id_match, 1'b1);
        check("stall_ts_match", ts_match, 1'b1);
        check("stall_timeout", timeout_err, 1'b0);
        id_wait_cfg = 0;
        tick();
        tick();

        // ID mismatch
        id_word = 32'hDEAD_BEEF;
        run_check(cyc);
        check("mis_ts_read_c3", rd_hist[3], 1'b1);
        check("mis_ts_addr_c3", addr_hist[3], 1'b1);
        check("mis_done_cycle", cyc, 5);
        check("mis_id_value", id_value, 32'hDEAD_BEEF);
        check("mis_id_match", id_match, 1'b0);
        check("mis_ts_match", ts_match, 1'b1);
        check("mis_timeout", timeout_err, 1'b0);
        id_word = EXP_ID;
        tick();
        tick();

        // Timeout on TS read
        ts_drop = 1'b1;
        run_check(cyc);
        check("to_ts_read_c3", rd_hist[3], 1'b1);
        check("to_ts_addr_c3", addr_hist[3], 1'b1);
        check("to_done_cycle", cyc, 11);
        check("to_timeout", timeout_err, 1'b1);
        check("to_m_read", m_read, 1'b0);
        check("to_busy", busy, 1'b0);
        check("to_id_value", id_value, EXP_ID);
        check("to_id_match", id_match, 1'b1);
        check("to_ts_value_kept", ts_value, EXP_TS);
        check("to_ts_match", ts_match, 1'b0);
        ts_drop = 1'b0;
        tick();
        check("to_done_pulse", done, 1'b0);
        check("to_timeout_hold", timeout_err, 1'b1);
        tick();

        // start held during busy
        ndone = 0;
        d1 = 0;
        d2 = 0;
        for (int c = 0; c < 15; c++) begin
            start = (c < 10);
            tick();
            if (done) begin
                ndone++;
                if (ndone == 1) d1 = c + 1;
                else if (ndone == 2) d2 = c + 1;
            end
        end
        start = 1'b0;
        check("busy_ndone", ndone, 2);
        check("busy_first_done", d1, 5);
        check("busy_second_done", d2, 10);
        check("busy_idle_end", busy, 1'b0);
        check("busy_timeout", timeout_err, 1'b0);
        tick();

        // Reset during RD_TS_WAIT
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("rmid_busy_before", busy, 1'b1);
        check("rmid_id_before", id_value, EXP_ID);
        reset_n = 1'b0;
        #1;
        check("rmid_busy", busy, 1'b0);
        check("rmid_id_value", id_value, 32'h0);
        check("rmid_id_match", id_match, 1'b0);
        check("rmid_m_read", m_read, 1'b0);
        @(negedge clock);
        #1;
        reset_n = 1'b1;
        tick();
        check("rmid_late_ts", ts_value, 32'h0);
        check("rmid_late_match", ts_match, 1'b0);
        check("rmid_late_busy", busy, 1'b0);
        ndone = 0;
        for (int c = 0; c < 6; c++) begin
            if (done) ndone++;
            tick();
        end
        check("rmid_no_done", ndone, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
